multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control unit for the 8-bit processor core.
- Fetches each 8-bit instruction over a request/valid handshake and sequences it through FETCH/DECODE/EXEC/WB.
- Drives the sign-extender select, ALU controls, register-file write and PC update.
- Replaces the single-cycle decoder so that instruction memory may take several cycles to respond.

Parameters:
- FETCH_TIMEOUT, 15: maximum wait cycles in FETCH before a fault is raised (1..255).
- CNT_W, 8: width of the retired-instruction counter.

Ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- Instr_Code  in  8  instruction from memory; sampled only when Instr_Valid=1 in FETCH
- Instr_Valid  in  1  memory response valid
- Zero_Flag  in  1  ALU zero flag from the previous result, sampled in EXEC
- Instr_Req  out  1  fetch request; held high in FETCH until Instr_Valid
- Ext_Sel  out  1  sign-extend select: 1 = 6-bit field [5:0], 0 = 3-bit field [2:0]
- ALU_Src_Imm  out  1  ALU B operand: 1 = extended immediate, 0 = register rs
- ALU_Op  out  2  00 add, 01 pass-B, 10 PC+imm, 11 PC+1
- Reg_Write  out  1  one-cycle register-file write strobe
- Rd_Addr  out  3  destination register = IR[5:3]
- PC_Write  out  1  one-cycle PC load strobe
- Halted  out  1  core stopped
- Fault  out  1  fetch timeout occurred (sticky)
- Retired_Count  out  CNT_W  instructions completed, wraps modulo 2^CNT_W

Behaviour:
- ISA, opcode IR[7:6]:
  - 00 ADD rd,rs: rd=IR[5:3], rs=IR[2:0].
  - 01 ADDI rd,imm3: immediate IR[2:0], Ext_Sel=0.
  - 10 BZ imm6: if Zero_Flag, PC=PC+sext(IR[5:0]), else PC+1; Ext_Sel=1.
  - 11 J imm6: PC=PC+sext(IR[5:0]); J with imm6=0 is HALT.
- Reset (asynchronous, Reset_n=0):
  - state=IDLE, IR=0, timeout count=0, Retired_Count=0, Fault=0.
  - All outputs 0.
- IDLE -> FETCH unconditionally on the first clock after reset release.
- FETCH:
  - Instr_Req=1.
  - If Instr_Valid: IR<=Instr_Code, go to DECODE.
  - Otherwise increment the wait counter. When the counter reaches FETCH_TIMEOUT with no valid: set Fault=1, go to HALT.
  - Valid arriving in the same cycle the counter reaches FETCH_TIMEOUT is accepted; no fault.
- Instr_Valid outside FETCH is ignored.
- DECODE (1 cycle): Ext_Sel, ALU_Src_Imm and ALU_Op become valid, decoded combinationally from IR. They are held stable through WB.
- EXEC (1 cycle): Zero_Flag is sampled here for BZ.
  - BZ, J: PC_Write=1, ALU_Op=10 if taken, else 11. Retire, then go to FETCH.
  - J with imm6=0: no PC_Write, go to HALT. It counts as retired.
  - ADD, ADDI: go to WB.
- WB (1 cycle): Reg_Write=1, PC_Write=1, ALU_Op=11. Go to FETCH.
- Latency: ALU ops take 4 cycles plus fetch wait; branches take 3 cycles plus fetch wait.
- Retire: Retired_Count increments on the last cycle of each instruction. It wraps from 2^CNT_W-1 to 0.
- HALT:
  - Halted=1, Instr_Req=0, all strobes 0.
  - Only reset leaves HALT.
  - Fault is cleared only by reset.
- Reset asserted mid-instruction aborts immediately; no partial strobe is issued.
- Reg_Write and PC_Write are never high in the same cycle outside WB, and never high for 2 consecutive cycles.

Decomposition:
- Shared package ctrl_pkg:
  - state enum {IDLE, FETCH, DECODE, EXEC, WB, HALT}
  - opcode constants OP_ADD=2'b00, OP_ADDI=2'b01, OP_BZ=2'b10, OP_J=2'b11
  - ALU_Op encodings
- One natural sub-module: ctrl_decode, purely combinational IR -> {Ext_Sel, ALU_Src_Imm, ALU_Op, is_halt}. It is reused by the single-cycle top.
- State register, timeout counter and retire counter stay in multicycle_ctrl.

Test Plan:
- Reset mid-DECODE (Reset_n low for 1 cycle) -> all outputs 0 immediately; IDLE then FETCH with Instr_Req=1 two cycles after release.
- Instr_Code=8'b01_011_101 (ADDI r3,-3), valid after 2 wait cycles:
  - Ext_Sel=0, ALU_Src_Imm=1, ALU_Op=00 from DECODE.
  - Reg_Write=1 with Rd_Addr=3 exactly 3 cycles after accept.
  - Retired_Count=1.
- Instr_Code=8'b10_111110 (BZ -2):
  - Zero_Flag=1 -> Ext_Sel=1, PC_Write=1, ALU_Op=10 in EXEC.
  - Zero_Flag=0 -> ALU_Op=11.
  - Reg_Write stays 0 in both cases.
- Instr_Valid held low: Fault=1 and Halted=1 after exactly 15 FETCH cycles. Repeat with valid on wait 15 -> accepted, Fault stays 0.
- Instr_Code=8'hC0 (J 0) -> Halted=1 after EXEC, no PC_Write, Instr_Req stays 0 for 20 cycles, Retired_Count incremented.
- 256 back-to-back ADD instructions with CNT_W=8 -> Retired_Count wraps to 0. Reg_Write and PC_Write are never high on consecutive cycles.

Source files
------------

// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the 8-bit core control units: FSM state encoding,
// instruction opcodes (IR[7:6]), ALU operation encodings and an opcode helper.
// -----------------------------------------------------------------------------
package ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      WB,
      HALT
   } state_t;

   // Opcodes, IR[7:6]
   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_ADDI = 2'b01;
   localparam logic [1:0] OP_BZ   = 2'b10;
   localparam logic [1:0] OP_J    = 2'b11;

   // ALU_Op encodings
   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_PASS_B = 2'b01;
   localparam logic [1:0] ALU_PC_IMM = 2'b10;
   localparam logic [1:0] ALU_PC_INC = 2'b11;

   function automatic logic [1:0] opcode_of(input logic [7:0] ir);
      return ir[7:6];
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Purely combinational instruction decoder, shared by the single-cycle and
// multi-cycle control units.
//
// Ports:
//   ir          in  8  instruction register
//   ext_sel     out 1  1 = sign-extend IR[5:0], 0 = sign-extend IR[2:0]
//   alu_src_imm out 1  1 = ALU B is the extended immediate, 0 = register rs
//   alu_op      out 2  ALU operation (branches report the taken form, PC+imm)
//   is_halt     out 1  instruction is J with imm6 = 0
// -----------------------------------------------------------------------------
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [7:0] ir,
   output logic       ext_sel,
   output logic       alu_src_imm,
   output logic [1:0] alu_op,
   output logic       is_halt
);

   // NOTE: every output gets a default before the case so that no path through
   // the block leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      ext_sel     = 1'b0;
      alu_src_imm = 1'b0;
      alu_op      = ALU_ADD;
      is_halt     = 1'b0;
      case (opcode_of(ir))
         OP_ADD: ;
         OP_ADDI: alu_src_imm = 1'b1;
         OP_BZ: begin
            ext_sel     = 1'b1;
            alu_src_imm = 1'b1;
            alu_op      = ALU_PC_IMM;
         end
         OP_J: begin
            ext_sel     = 1'b1;
            alu_src_imm = 1'b1;
            alu_op      = ALU_PC_IMM;
            is_halt     = (ir[5:0] == 6'd0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle control unit for the 8-bit core. Fetches each instruction over a
// request/valid handshake and sequences it through FETCH/DECODE/EXEC/WB.
// ALU ops take 4 cycles plus fetch wait, branches 3 cycles plus fetch wait.
//
// Ports:
//   Clk            in  1      rising-edge clock
//   Reset_n        in  1      asynchronous active-low reset
//   Instr_Code     in  8      instruction, captured when Instr_Valid in FETCH
//   Instr_Valid    in  1      memory response valid (ignored outside FETCH)
//   Zero_Flag      in  1      ALU zero flag, sampled in EXEC for BZ
//   Instr_Req      out 1      fetch request, high throughout FETCH
//   Ext_Sel        out 1      sign-extend select (valid DECODE..WB)
//   ALU_Src_Imm    out 1      ALU B operand select (valid DECODE..WB)
//   ALU_Op         out 2      ALU operation (valid DECODE..WB)
//   Reg_Write      out 1      register-file write strobe (WB only)
//   Rd_Addr        out 3      destination register IR[5:3] (valid DECODE..WB)
//   PC_Write       out 1      PC load strobe (EXEC for branches, WB for ALU)
//   Halted         out 1      core stopped; only reset leaves
//   Fault          out 1      sticky fetch-timeout flag
//   Retired_Count  out CNT_W  retired instructions, wraps
// -----------------------------------------------------------------------------
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned FETCH_TIMEOUT = 15,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [7:0]       Instr_Code,
   input  logic             Instr_Valid,
   input  logic             Zero_Flag,
   output logic             Instr_Req,
   output logic             Ext_Sel,
   output logic             ALU_Src_Imm,
   output logic [1:0]       ALU_Op,
   output logic             Reg_Write,
   output logic [2:0]       Rd_Addr,
   output logic             PC_Write,
   output logic             Halted,
   output logic             Fault,
   output logic [CNT_W-1:0] Retired_Count
);

   // Wait-count value seen in the last FETCH cycle allowed before a fault.
   localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       ir;
   logic [7:0]       wait_cnt;
   logic [CNT_W-1:0] retired_cnt;
   logic             fault_q;

   logic             ir_load;
   logic             retire;
   logic             fault_set;
   logic             dec_valid;

   logic             dec_ext_sel;
   logic             dec_alu_src_imm;
   logic [1:0]       dec_alu_op;
   logic             dec_is_halt;

   ctrl_decode u_decode (
      .ir          (ir),
      .ext_sel     (dec_ext_sel),
      .alu_src_imm (dec_alu_src_imm),
      .alu_op      (dec_alu_op),
      .is_halt     (dec_is_halt)
   );

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= IDLE;
         ir          <= '0;
         wait_cnt    <= '0;
         retired_cnt <= '0;
         fault_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (ir_load) ir <= Instr_Code;
         // Counts consecutive FETCH cycles without a response.
         if (state == FETCH && !Instr_Valid) wait_cnt <= wait_cnt + 8'd1;
         else                                wait_cnt <= '0;
         if (retire)    retired_cnt <= retired_cnt + CNT_W'(1);
         if (fault_set) fault_q     <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      ir_load   = 1'b0;
      retire    = 1'b0;
      fault_set = 1'b0;
      dec_valid = 1'b0;
      Instr_Req = 1'b0;
      Reg_Write = 1'b0;
      PC_Write  = 1'b0;
      ALU_Op    = 2'b00;
      case (state)
         IDLE: state_nxt = FETCH;
         FETCH: begin
            Instr_Req = 1'b1;
            // A response in the final allowed cycle still wins over the fault.
            if (Instr_Valid) begin
               ir_load   = 1'b1;
               state_nxt = DECODE;
            end else if (wait_cnt == TIMEOUT_LAST) begin
               fault_set = 1'b1;
               state_nxt = HALT;
            end
         end
         DECODE: begin
            dec_valid = 1'b1;
            ALU_Op    = dec_alu_op;
            state_nxt = EXEC;
         end
         EXEC: begin
            dec_valid = 1'b1;
            ALU_Op    = dec_alu_op;
            if (opcode_of(ir) == OP_BZ || opcode_of(ir) == OP_J) begin
               retire = 1'b1;
               if (dec_is_halt) begin
                  state_nxt = HALT;
               end else begin
                  PC_Write  = 1'b1;
                  state_nxt = FETCH;
                  // Untaken BZ falls through to PC+1.
                  if (opcode_of(ir) == OP_BZ && !Zero_Flag) ALU_Op = ALU_PC_INC;
               end
            end else begin
               state_nxt = WB;
            end
         end
         WB: begin
            dec_valid = 1'b1;
            Reg_Write = 1'b1;
            PC_Write  = 1'b1;
            ALU_Op    = ALU_PC_INC;
            retire    = 1'b1;
            state_nxt = FETCH;
         end
         HALT: ;
         default: state_nxt = IDLE;
      endcase
   end

   assign Ext_Sel       = dec_valid & dec_ext_sel;
   assign ALU_Src_Imm   = dec_valid & dec_alu_src_imm;
   assign Rd_Addr       = dec_valid ? ir[5:3] : 3'd0;
   assign Halted        = (state == HALT);
   assign Fault         = fault_q;
   assign Retired_Count = retired_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed self-checking bench for multicycle_ctrl. Inputs change and outputs
// are sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic [7:0] Instr_Code;
   logic       Instr_Valid;
   logic       Zero_Flag;
   logic       Instr_Req;
   logic       Ext_Sel;
   logic       ALU_Src_Imm;
   logic [1:0] ALU_Op;
   logic       Reg_Write;
   logic [2:0] Rd_Addr;
   logic       PC_Write;
   logic       Halted;
   logic       Fault;
   logic [7:0] Retired_Count;

   int n_assert = 0;
   int n_fail   = 0;

   // Strobe history for the back-to-back run.
   logic prev_rw = 1'b0;
   logic prev_pw = 1'b0;
   int   n_viol  = 0;
   int   n_rw    = 0;

   multicycle_ctrl #(
      .FETCH_TIMEOUT (15),
      .CNT_W         (8)
   ) dut (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .Instr_Code    (Instr_Code),
      .Instr_Valid   (Instr_Valid),
      .Zero_Flag     (Zero_Flag),
      .Instr_Req     (Instr_Req),
      .Ext_Sel       (Ext_Sel),
      .ALU_Src_Imm   (ALU_Src_Imm),
      .ALU_Op        (ALU_Op),
      .Reg_Write     (Reg_Write),
      .Rd_Addr       (Rd_Addr),
      .PC_Write      (PC_Write),
      .Halted        (Halted),
      .Fault         (Fault),
      .Retired_Count (Retired_Count)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Tick while tracking consecutive-cycle strobe activity.
   task automatic step();
      tick();
      if (Reg_Write && prev_rw) n_viol++;
      if (PC_Write && prev_pw)  n_viol++;
      if (Reg_Write) n_rw++;
      prev_rw = Reg_Write;
      prev_pw = PC_Write;
   endtask

   function automatic logic [19:0] all_outputs();
      return {Instr_Req, Ext_Sel, ALU_Src_Imm, ALU_Op, Reg_Write, Rd_Addr,
              PC_Write, Halted, Fault, Retired_Count};
   endfunction

   // Assert reset across one edge, release it, and land in FETCH.
   task automatic do_reset();
      Reset_n     = 1'b0;
      Instr_Valid = 1'b0;
      #1;
      check("reset_all_zero", all_outputs(), 20'd0);
      tick();
      Reset_n = 1'b1;
      #1;
      check("idle_no_req", Instr_Req, 1'b0);
      tick();
      check("fetch_req", Instr_Req, 1'b1);
   endtask

   int n_busy;

   initial begin
      Reset_n     = 1'b0;
      Instr_Code  = 8'h00;
      Instr_Valid = 1'b0;
      Zero_Flag   = 1'b0;
      #12;
      check("por_all_zero", all_outputs(), 20'd0);
      Reset_n = 1'b1;
      #1;
      check("por_idle_no_req", Instr_Req, 1'b0);
      tick();
      check("por_fetch_req", Instr_Req, 1'b1);

      // ---- Reset mid-DECODE: ADD r1,r2 ----
      Instr_Code  = 8'b00_001_010;
      Instr_Valid = 1'b1;
      tick();
      Instr_Valid = 1'b0;
      check("add_dec_src", ALU_Src_Imm, 1'b0);
      check("add_dec_rd", Rd_Addr, 3'd1);
      check("add_dec_req", Instr_Req, 1'b0);
      do_reset();

      // ---- ADDI r3,-3 after 2 wait cycles ----
      tick();
      tick();
      check("addi_wait_req", Instr_Req, 1'b1);
      Instr_Code  = 8'b01_011_101;
      Instr_Valid = 1'b1;
      tick();
      Instr_Valid = 1'b0;
      check("addi_dec_ext", Ext_Sel, 1'b0);
      check("addi_dec_src", ALU_Src_Imm, 1'b1);
      check("addi_dec_op", ALU_Op, 2'b00);
      check("addi_dec_strobes", {Reg_Write, PC_Write, Instr_Req}, 3'b000);
      tick();
      check("addi_exec_op", ALU_Op, 2'b00);
      check("addi_exec_strobes", {Reg_Write, PC_Write}, 2'b00);
      tick();
      check("addi_wb_strobes", {Reg_Write, PC_Write}, 2'b11);
      check("addi_wb_rd", Rd_Addr, 3'd3);
      check("addi_wb_op", ALU_Op, 2'b11);
      check("addi_wb_src", ALU_Src_Imm, 1'b1);
      tick();
      check("addi_retired", Retired_Count, 8'd1);
      check("addi_back_fetch", {Instr_Req, Reg_Write, PC_Write}, 3'b100);

      // ---- BZ -2, taken ----
      Instr_Code  = 8'b10_111110;
      Instr_Valid = 1'b1;
      Zero_Flag   = 1'b1;
      tick();
      Instr_Valid = 1'b0;
      check("bz_dec_sel", {Ext_Sel, ALU_Src_Imm, ALU_Op}, 4'b1110);
      tick();
      check("bz_t_exec_pcw", PC_Write, 1'b1);
      check("bz_t_exec_op", ALU_Op, 2'b10);
      check("bz_t_exec_ext", Ext_Sel, 1'b1);
      check("bz_t_exec_rw", Reg_Write, 1'b0);
      tick();
      check("bz_t_retired", Retired_Count, 8'd2);
      check("bz_t_fetch", {Instr_Req, PC_Write, Reg_Write}, 3'b100);

      // ---- BZ -2, not taken ----
      Instr_Valid = 1'b1;
      Zero_Flag   = 1'b0;
      tick();
      Instr_Valid = 1'b0;
      tick();
      check("bz_nt_exec_pcw", PC_Write, 1'b1);
      check("bz_nt_exec_op", ALU_Op, 2'b11);
      check("bz_nt_exec_rw", Reg_Write, 1'b0);
      tick();
      check("bz_nt_retired", Retired_Count, 8'd3);

      // ---- Valid on the 15th FETCH cycle is accepted ----
      for (int i = 0; i < 14; i++) tick();
      check("to15_req", {Instr_Req, Halted}, 2'b10);
      Instr_Code  = 8'h00;
      Instr_Valid = 1'b1;
      tick();
      Instr_Valid = 1'b0;
      check("to15_no_fault", {Fault, Halted, Instr_Req}, 3'b000);
      tick();
      tick();
      tick();
      check("to15_retired", Retired_Count, 8'd4);

      // ---- No valid for 15 FETCH cycles -> fault ----
      for (int i = 0; i < 14; i++) tick();
      check("to_pre_fault", {Instr_Req, Halted, Fault}, 3'b100);
      tick();
      check("to_fault", {Instr_Req, Halted, Fault}, 3'b011);
      check("to_retired_kept", Retired_Count, 8'd4);
      Instr_Valid = 1'b1;
      tick();
      tick();
      check("to_halt_ignores_valid", {Instr_Req, Halted, Fault}, 3'b011);
      do_reset();

      // ---- J 0 halts ----
      Instr_Code  = 8'hC0;
      Instr_Valid = 1'b1;
      tick();
      Instr_Valid = 1'b0;
      tick();
      check("halt_exec", {PC_Write, Reg_Write, Halted}, 3'b000);
      tick();
      check("halt_state", {Halted, Fault, PC_Write}, 3'b100);
      check("halt_retired", Retired_Count, 8'd1);
      n_busy = 0;
      for (int i = 0; i < 20; i++) begin
         Instr_Valid = i[0];
         tick();
         if (Instr_Req || PC_Write || Reg_Write || !Halted) n_busy++;
      end
      Instr_Valid = 1'b0;
      check("halt_idle_20", n_busy, 0);
      do_reset();

      // ---- 256 back-to-back ADDs: counter wrap and strobe spacing ----
      prev_rw = 1'b0;
      prev_pw = 1'b0;
      for (int i = 0; i < 256; i++) begin
         if (i == 255) check("wrap_pre", Retired_Count, 8'd255);
         Instr_Code  = {2'b00, 6'($urandom_range(0, 63))};
         Instr_Valid = 1'b1;
         step();
         Instr_Valid = 1'b0;
         step();
         step();
         step();
      end
      check("wrap_zero", Retired_Count, 8'd0);
      check("wrap_rw_pulses", n_rw, 256);
      check("wrap_no_consecutive", n_viol, 0);
      check("wrap_not_halted", {Halted, Fault}, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
